lab7_3_time_keeper: RTL and testbench
=====================================

// Module: lab7_3_time_keeper
// PURPOSE
//  Running time-of-day counter fed by the time-setting block: accepts a BCD HH:MM value
//  (f_h1,f_h2,f_m1,f_m2 from the setter) on a load request, validates it, then counts
//  seconds/minutes/hours forward in 24-hour format. Sits between the setter and display mux;
//  its outputs drive the 7-segment digits and the minute/day event logic.
// PARAMETERS
//  TICKS_PER_SEC  1   clk_1 cycles per counted second (prescaler terminal count, >=1)
// PORTS
//  clk_1      in   1  system clock
//  rst_n      in   1  asynchronous, active-low reset
//  load_req   in   1  level; request to load ld_h1..ld_m2 (held until load_ack or load_err)
//  ld_h1      in   4  BCD hour tens to load (0-2)
//  ld_h2      in   4  BCD hour units to load (0-9, <=3 when ld_h1==2)
//  ld_m1      in   4  BCD minute tens to load (0-5)
//  ld_m2      in   4  BCD minute units to load (0-9)
//  run        in   1  1 = count, 0 = hold (pause)
//  load_ack   out  1  1-cycle pulse: value accepted and written
//  load_err   out  1  1-cycle pulse: value rejected (illegal BCD/time), time unchanged
//  h1,h2      out  4  current hour BCD digits
//  m1,m2      out  4  current minute BCD digits
//  s1,s2      out  4  current second BCD digits
//  min_tick   out  1  1-cycle pulse when seconds wrap 59->00
//  day_wrap   out  1  1-cycle pulse when time wraps 23:59:59->00:00:00
// BEHAVIOUR
//  Reset: all digits 0 (00:00:00), prescaler 0, load_ack=load_err=min_tick=day_wrap=0, FSM=IDLE.
//  FSM: IDLE (holding), RUN (counting), LOADED (1-cycle handshake-complete state).
//   IDLE -> RUN when run=1; RUN -> IDLE when run=0 (prescaler holds its value, not cleared).
//   Any state, load_req=1 and not in LOADED -> check value on that edge:
//    legal  -> write digits, s1=s2=0, prescaler=0, load_ack=1 next cycle, go LOADED.
//    illegal-> no write, load_err=1 next cycle, go LOADED.
//   LOADED -> RUN if run=1 else IDLE; LOADED ignores load_req (requester must drop load_req
//    after ack/err; a still-high load_req re-triggers from the following cycle).
//  Legal value: ld_h1<=2, ld_h2<=9, (ld_h1!=2 or ld_h2<=3), ld_m1<=5, ld_m2<=9.
//  Prescaler: counts 0..TICKS_PER_SEC-1 in RUN only; second tick when it equals TPS-1
//   (TPS=1 -> every RUN cycle is a tick). Output latency: digits change on the tick edge.
//  Carry chain on tick: s2 9->0 carries s1; s1 5->0 carries m2 (min_tick); m2 9->0 -> m1;
//   m1 5->0 -> hour; h2 9->0 with h1+1; at 23 -> 00 (day_wrap, same cycle as min_tick).
//  Simultaneous load and tick: load wins, tick discarded, no min_tick/day_wrap.
//  run=0 with pending tick: no increment. Digits never leave legal range.
//  rst_n mid-load: abort, no ack/err, back to reset state.
// STRUCTURE
//  Shared package/header: FSM state codes (IDLE/RUN/LOADED), BCD limit constants
//   (SEC_TENS_MAX=5, UNIT_MAX=9, HOUR_TENS_MAX=2, HOUR_UNITS_MAX_AT_20=3).
//  One sub-module: lab7_3_bcd_digit_cnt (BCD digit, params MAX; inputs inc, clr;
//   output carry) instantiated for s2,s1,m2,m1; hour pair handled locally for the 23 wrap.
//  Registered outputs; combinational next-state/validation, registered update.
// TESTING
//  Reset then run=1, TPS=1, 60 cycles -> s1s2 00..59 then 00, min_tick once, m2=1.
//  Load 23:59 (legal), run=1, 60 ticks -> load_ack 1 cycle, then 00:00:00, day_wrap+min_tick same cycle.
//  Load 24:00 / 19:60 / 2F:00 -> load_err pulse each, time unchanged, no load_ack.
//  run=0 for 10 cycles mid-count at 12:34:56 -> digits frozen; run=1 resumes at 12:34:57.
//  load_req coincident with 12:59:59 tick -> load wins, loaded value with 00 s, no min_tick.
//  TPS=4: tick every 4th RUN cycle; pause at prescaler=2 resumes tick after 1 more RUN cycle;
//   rst_n low during load_req -> 00:00:00, no ack/err.

Source files
------------

// File: rtl/lab7_3_time_keeper_pkg.sv
// Shared types for the time keeper: FSM state codes, BCD digit limits, load legality check.
// Pure declarations; no latency or flow control of its own.
package lab7_3_time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOADED = 2'd2
    } tk_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX         = 4'd5;
    localparam bcd_t UNIT_MAX             = 4'd9;
    localparam bcd_t HOUR_TENS_MAX        = 4'd2;
    localparam bcd_t HOUR_UNITS_MAX_AT_20 = 4'd3;

    // Minute tens share the seconds-tens limit (both 0-5).
    function automatic logic bcd_time_legal(bcd_t h1, bcd_t h2, bcd_t m1, bcd_t m2);
        return (h1 <= HOUR_TENS_MAX) &&
               (h2 <= UNIT_MAX) &&
               ((h1 != HOUR_TENS_MAX) || (h2 <= HOUR_UNITS_MAX_AT_20)) &&
               (m1 <= SEC_TENS_MAX) &&
               (m2 <= UNIT_MAX);
    endfunction

endpackage

// File: rtl/lab7_3_time_keeper_if.sv
// Setter/display-side bundle of the time keeper: load handshake, run control, time digits, events.
// slave = time keeper, master = setter/display logic driving load and run.
interface lab7_3_time_keeper_if;
    import lab7_3_time_keeper_pkg::*;

    logic load_req;
    bcd_t ld_h1;
    bcd_t ld_h2;
    bcd_t ld_m1;
    bcd_t ld_m2;
    logic run;
    logic load_ack;
    logic load_err;
    bcd_t h1;
    bcd_t h2;
    bcd_t m1;
    bcd_t m2;
    bcd_t s1;
    bcd_t s2;
    logic min_tick;
    logic day_wrap;

    modport slave (
        input  load_req, ld_h1, ld_h2, ld_m1, ld_m2, run,
        output load_ack, load_err, h1, h2, m1, m2, s1, s2, min_tick, day_wrap
    );

    modport master (
        output load_req, ld_h1, ld_h2, ld_m1, ld_m2, run,
        input  load_ack, load_err, h1, h2, m1, m2, s1, s2, min_tick, day_wrap
    );

endinterface

// File: rtl/lab7_3_bcd_digit_cnt.sv
// One BCD digit 0..MAX with clear, parallel load and increment; carry is combinational on inc at MAX.
// Updates on the edge after inc/ld/clr; clr beats ld beats inc, no backpressure.
module lab7_3_bcd_digit_cnt
    import lab7_3_time_keeper_pkg::*;
#(
    parameter bcd_t MAX = UNIT_MAX
) (
    input  logic clk_1,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic carry
);

    assign carry = inc && (q == MAX);

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (inc) begin
            q <= carry ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/lab7_3_time_keeper.sv
// 24-hour HH:MM:SS counter with validated BCD load; digits and events change on the tick/load edge.
// Load handshake answers with a 1-cycle ack/err one cycle after the request edge; no other stalls.
module lab7_3_time_keeper
    import lab7_3_time_keeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic                 clk_1,
    input  logic                 rst_n,
    lab7_3_time_keeper_if.slave  tk
);

    localparam int            PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    tk_state_e     state_q;
    tk_state_e     state_d;
    logic [PW-1:0] presc_q;

    logic load_hit;
    logic ld_legal;
    logic load_wr;
    logic count_en;
    logic tick;

    logic s2_cy;
    logic s1_cy;
    logic m2_cy;
    logic m1_cy;
    logic at_23;

    bcd_t s2_q;
    bcd_t s1_q;
    bcd_t m2_q;
    bcd_t m1_q;
    bcd_t h1_q;
    bcd_t h2_q;

    logic load_ack_q;
    logic load_err_q;
    logic min_tick_q;
    logic day_wrap_q;

    // A load request outranks both run control and a coincident second tick.
    always_comb begin
        state_d  = state_q;
        load_hit = 1'b0;
        count_en = 1'b0;
        load_wr  = 1'b0;
        tick     = 1'b0;
        ld_legal = bcd_time_legal(tk.ld_h1, tk.ld_h2, tk.ld_m1, tk.ld_m2);

        case (state_q)
            ST_IDLE: begin
                if (tk.run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tk.run) begin
                    count_en = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOADED: begin
                state_d = tk.run ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tk.load_req && (state_q != ST_LOADED)) begin
            load_hit = 1'b1;
            count_en = 1'b0;
            state_d  = ST_LOADED;
        end

        load_wr = load_hit && ld_legal;
        tick    = count_en && (presc_q == PRESC_MAX);
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescaler keeps its count across a pause so the next second is not shortened or lost.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (load_wr) begin
            presc_q <= '0;
        end else if (count_en) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    lab7_3_bcd_digit_cnt #(.MAX(UNIT_MAX)) u_s2 (
        .clk_1  (clk_1),
        .rst_n  (rst_n),
        .inc    (tick),
        .clr    (load_wr),
        .ld     (1'b0),
        .ld_val (4'd0),
        .q      (s2_q),
        .carry  (s2_cy)
    );

    lab7_3_bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_s1 (
        .clk_1  (clk_1),
        .rst_n  (rst_n),
        .inc    (s2_cy),
        .clr    (load_wr),
        .ld     (1'b0),
        .ld_val (4'd0),
        .q      (s1_q),
        .carry  (s1_cy)
    );

    lab7_3_bcd_digit_cnt #(.MAX(UNIT_MAX)) u_m2 (
        .clk_1  (clk_1),
        .rst_n  (rst_n),
        .inc    (s1_cy),
        .clr    (1'b0),
        .ld     (load_wr),
        .ld_val (tk.ld_m2),
        .q      (m2_q),
        .carry  (m2_cy)
    );

    lab7_3_bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_m1 (
        .clk_1  (clk_1),
        .rst_n  (rst_n),
        .inc    (m2_cy),
        .clr    (1'b0),
        .ld     (load_wr),
        .ld_val (tk.ld_m1),
        .q      (m1_q),
        .carry  (m1_cy)
    );

    // Hours are a coupled pair: the units limit depends on the tens digit, so no generic counter.
    assign at_23 = (h1_q == HOUR_TENS_MAX) && (h2_q == HOUR_UNITS_MAX_AT_20);

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= '0;
            h2_q <= '0;
        end else if (load_wr) begin
            h1_q <= tk.ld_h1;
            h2_q <= tk.ld_h2;
        end else if (m1_cy) begin
            if (at_23) begin
                h1_q <= '0;
                h2_q <= '0;
            end else if (h2_q == UNIT_MAX) begin
                h1_q <= h1_q + 4'd1;
                h2_q <= '0;
            end else begin
                h2_q <= h2_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
            min_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            load_ack_q <= load_wr;
            load_err_q <= load_hit && !ld_legal;
            min_tick_q <= s1_cy;
            day_wrap_q <= m1_cy && at_23;
        end
    end

    assign tk.load_ack = load_ack_q;
    assign tk.load_err = load_err_q;
    assign tk.min_tick = min_tick_q;
    assign tk.day_wrap = day_wrap_q;
    assign tk.h1       = h1_q;
    assign tk.h2       = h2_q;
    assign tk.m1       = m1_q;
    assign tk.m2       = m2_q;
    assign tk.s1       = s1_q;
    assign tk.s2       = s2_q;

    a_time_legal: assert property (@(posedge clk_1) disable iff (!rst_n)
        bcd_time_legal(h1_q, h2_q, m1_q, m2_q) && (s1_q <= SEC_TENS_MAX) && (s2_q <= UNIT_MAX));

    a_ack_err_excl: assert property (@(posedge clk_1) disable iff (!rst_n)
        !(load_ack_q && load_err_q));

    a_day_with_min: assert property (@(posedge clk_1) disable iff (!rst_n)
        day_wrap_q |-> min_tick_q);

endmodule

// File: tb/tb_lab7_3_time_keeper.sv
// Directed bench: one keeper at one tick per cycle, one at four cycles per second, shared clock/reset.
module tb_lab7_3_time_keeper;

    logic clk_1 = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_1 = ~clk_1;

    lab7_3_time_keeper_if if1 ();
    lab7_3_time_keeper_if if4 ();

    lab7_3_time_keeper #(.TICKS_PER_SEC(1)) u_dut1 (
        .clk_1 (clk_1),
        .rst_n (rst_n),
        .tk    (if1)
    );

    lab7_3_time_keeper #(.TICKS_PER_SEC(4)) u_dut4 (
        .clk_1 (clk_1),
        .rst_n (rst_n),
        .tk    (if4)
    );

    logic [31:0] tod1;
    logic [31:0] tod4;
    logic [31:0] sec4;
    assign tod1 = {8'h00, if1.h1, if1.h2, if1.m1, if1.m2, if1.s1, if1.s2};
    assign tod4 = {8'h00, if4.h1, if4.h2, if4.m1, if4.m2, if4.s1, if4.s2};
    assign sec4 = {24'h0, if4.s1, if4.s2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_1);
        #1;
    endtask

    function automatic logic [31:0] bcd2(input int v);
        logic [31:0] r;
        r = {24'h0, 4'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic load1(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        if1.ld_h1    = a;
        if1.ld_h2    = b;
        if1.ld_m1    = c;
        if1.ld_m2    = d;
        if1.load_req = 1'b1;
    endtask

    logic [15:0] bad_vec [3];
    int          mt_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        if1.load_req = 0; if1.run = 0;
        if1.ld_h1 = 0; if1.ld_h2 = 0; if1.ld_m1 = 0; if1.ld_m2 = 0;
        if4.load_req = 0; if4.run = 0;
        if4.ld_h1 = 0; if4.ld_h2 = 0; if4.ld_m1 = 0; if4.ld_m2 = 0;
        bad_vec[0] = 16'h2400;
        bad_vec[1] = 16'h1960;
        bad_vec[2] = 16'h2F00;

        step(3);
        chk("reset_tod1", tod1, 32'h0);
        chk("reset_tod4", tod4, 32'h0);
        chk("reset_ack", 32'(if1.load_ack), 32'h0);
        chk("reset_err", 32'(if1.load_err), 32'h0);
        chk("reset_min", 32'(if1.min_tick), 32'h0);
        chk("reset_day", 32'(if1.day_wrap), 32'h0);
        rst_n = 1'b1;

        // Free run from reset: first edge leaves IDLE, each later edge is a second.
        if1.run = 1'b1;
        mt_cnt  = 0;
        for (int i = 1; i <= 61; i++) begin
            step(1);
            chk("sec_run", {24'h0, if1.s1, if1.s2}, bcd2((i - 1) % 60));
            mt_cnt += int'(if1.min_tick);
            if (i == 61) chk("min_tick_at_wrap", 32'(if1.min_tick), 32'h1);
        end
        chk("min_tick_count", 32'(mt_cnt), 32'h1);
        chk("tod_after_minute", tod1, 32'h000100);
        if1.run = 1'b0;
        step(1);
        chk("stop_hold", tod1, 32'h000100);

        // Load 23:59 and run through midnight.
        load1(4'd2, 4'd3, 4'd5, 4'd9);
        step(1);
        chk("load2359_tod", tod1, 32'h235900);
        chk("load2359_ack", 32'(if1.load_ack), 32'h1);
        chk("load2359_err", 32'(if1.load_err), 32'h0);
        if1.load_req = 1'b0;
        if1.run      = 1'b1;
        step(1);
        chk("ack_one_cycle", 32'(if1.load_ack), 32'h0);
        chk("loaded_no_count", tod1, 32'h235900);
        step(59);
        chk("pre_midnight", tod1, 32'h235959);
        chk("pre_midnight_day", 32'(if1.day_wrap), 32'h0);
        step(1);
        chk("midnight_tod", tod1, 32'h0);
        chk("midnight_day", 32'(if1.day_wrap), 32'h1);
        chk("midnight_min", 32'(if1.min_tick), 32'h1);
        step(1);
        chk("post_midnight_tod", tod1, 32'h000001);
        chk("post_midnight_day", 32'(if1.day_wrap), 32'h0);
        chk("post_midnight_min", 32'(if1.min_tick), 32'h0);
        if1.run = 1'b0;
        step(1);
        chk("idle_again", tod1, 32'h000001);

        // Illegal loads: error pulse, no write, no ack.
        for (int v = 0; v < 3; v++) begin
            load1(bad_vec[v][15:12], bad_vec[v][11:8], bad_vec[v][7:4], bad_vec[v][3:0]);
            step(1);
            chk("bad_err", 32'(if1.load_err), 32'h1);
            chk("bad_ack", 32'(if1.load_ack), 32'h0);
            chk("bad_tod", tod1, 32'h000001);
            if1.load_req = 1'b0;
            step(1);
            chk("bad_err_clear", 32'(if1.load_err), 32'h0);
        end

        // Pause at 12:34:56.
        load1(4'd1, 4'd2, 4'd3, 4'd4);
        step(1);
        chk("load1234", tod1, 32'h123400);
        if1.load_req = 1'b0;
        if1.run      = 1'b1;
        step(57);
        chk("at_123456", tod1, 32'h123456);
        if1.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("paused", tod1, 32'h123456);
        end
        if1.run = 1'b1;
        step(1);
        chk("resume_idle_to_run", tod1, 32'h123456);
        step(1);
        chk("resume_tick", tod1, 32'h123457);
        if1.run = 1'b0;
        step(1);

        // Load coincident with the 12:59:59 -> 13:00:00 tick.
        load1(4'd1, 4'd2, 4'd5, 4'd9);
        step(1);
        chk("load1259", tod1, 32'h125900);
        if1.load_req = 1'b0;
        if1.run      = 1'b1;
        step(60);
        chk("at_125959", tod1, 32'h125959);
        load1(4'd0, 4'd8, 4'd1, 4'd5);
        step(1);
        chk("collide_tod", tod1, 32'h081500);
        chk("collide_ack", 32'(if1.load_ack), 32'h1);
        chk("collide_min", 32'(if1.min_tick), 32'h0);
        chk("collide_day", 32'(if1.day_wrap), 32'h0);
        if1.load_req = 1'b0;
        if1.run      = 1'b0;
        step(1);
        chk("collide_after_min", 32'(if1.min_tick), 32'h0);
        chk("collide_after_tod", tod1, 32'h081500);

        // Four clock cycles per second.
        if4.run = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step(1);
            chk("tps4_sec", sec4, (e >= 9) ? 32'h2 : ((e >= 5) ? 32'h1 : 32'h0));
        end
        step(2);
        if4.run = 1'b0;
        step(4);
        chk("tps4_paused", sec4, 32'h2);
        if4.run = 1'b1;
        step(1);
        chk("tps4_resume_a", sec4, 32'h2);
        step(1);
        chk("tps4_resume_b", sec4, 32'h2);
        step(1);
        chk("tps4_resume_tick", sec4, 32'h3);

        // Reset arriving while a load is being requested.
        if4.run      = 1'b0;
        if4.ld_h1    = 4'd1;
        if4.ld_h2    = 4'd1;
        if4.ld_m1    = 4'd1;
        if4.ld_m2    = 4'd1;
        if4.load_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_load_tod", tod4, 32'h0);
        step(2);
        chk("rst_mid_load_ack", 32'(if4.load_ack), 32'h0);
        chk("rst_mid_load_err", 32'(if4.load_err), 32'h0);
        if4.load_req = 1'b0;
        rst_n        = 1'b1;
        step(1);
        chk("rst_release_tod", tod4, 32'h0);
        chk("rst_release_ack", 32'(if4.load_ack), 32'h0);
        chk("rst_release_err", 32'(if4.load_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
